mipi_csi_rx_raw_depacker_8b4lane: RTL and testbench

Unpacks stripped CSI-2 RAW10/RAW12/RAW14 payload bytes into 4-pixel groups. It sits directly downstream of the 8-bit 4-lane packet decoder and consumes that stage's payload word, valid, packet type and packet length. Each pixel is presented right-justified and zero-extended in a 16-bit field, so later stages see one format regardless of bit depth.

---
 rtl/mipi_csi_rx_raw_depacker_8b4lane_if.sv | 21 ++
 rtl/mipi_csi_rx_raw_depacker_8b4lane.sv | 134 +++++++++++++
 tb/tb_mipi_csi_rx_raw_depacker_8b4lane.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_csi_rx_raw_depacker_8b4lane_if.sv
// Payload-in / pixel-out bundle between the CSI-2 packet decoder and the RAW depacker.
// master = payload source (decoder side), slave = the depacker itself.
interface mipi_csi_rx_raw_depacker_8b4lane_if;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic [2:0]  packet_type_i;
  logic [15:0] packet_length_i;
  logic        output_valid_o;
  logic [63:0] pixel_data_o;
  logic [1:0]  pixel_depth_o;

  modport master (
    output data_valid_i, data_i, packet_type_i, packet_length_i,
    input  output_valid_o, pixel_data_o, pixel_depth_o
  );

  modport slave (
    input  data_valid_i, data_i, packet_type_i, packet_length_i,
    output output_valid_o, pixel_data_o, pixel_depth_o
  );
endinterface

// File: rtl/mipi_csi_rx_raw_depacker_8b4lane.sv
// Unpacks 4-byte CSI-2 RAW10/12/14 payload words into groups of four 16-bit pixels.
// A 10-byte accumulator absorbs the mismatch between 4-byte words and 5/6/7-byte groups.
module mipi_csi_rx_raw_depacker_8b4lane (
  input  logic clk_i,
  input  logic reset_i,
  mipi_csi_rx_raw_depacker_8b4lane_if.slave bus
);
  localparam logic [2:0] TYPE_RAW10 = 3'd3;
  localparam logic [2:0] TYPE_RAW12 = 3'd4;
  localparam logic [2:0] TYPE_RAW14 = 3'd5;

  logic        in_packet_q;
  logic [2:0]  type_q;
  logic [15:0] remaining_q;
  logic [3:0]  count_q;
  logic [7:0]  byte_buf_q [10];
  logic        out_valid_q;
  logic [63:0] pixel_q;
  logic [1:0]  depth_q;

  logic        start;
  logic [2:0]  cur_type;
  logic [15:0] cur_remaining;
  logic [3:0]  group_size;
  logic [1:0]  depth;
  logic [2:0]  take;
  logic [4:0]  total;
  logic        emit;
  logic [7:0]  in_byte [4];
  logic [7:0]  merged [10];
  logic [7:0]  shifted [10];
  logic [63:0] pixels;

  // Header fields are taken straight from the inputs on the start cycle so its bytes count too.
  always_comb begin
    start         = bus.data_valid_i && !in_packet_q;
    cur_type      = start ? bus.packet_type_i : type_q;
    cur_remaining = start ? bus.packet_length_i : remaining_q;
    group_size    = 4'd0;
    depth         = 2'd0;
    case (cur_type)
      TYPE_RAW10: begin group_size = 4'd5; depth = 2'd1; end
      TYPE_RAW12: begin group_size = 4'd6; depth = 2'd2; end
      TYPE_RAW14: begin group_size = 4'd7; depth = 2'd3; end
      default:    ;
    endcase
    take = 3'd0;
    if (group_size != 4'd0)
      take = (cur_remaining >= 16'd4) ? 3'd4 : cur_remaining[2:0];
    total = {1'b0, count_q} + {2'b00, take};
    emit  = (group_size != 4'd0) && (total >= {1'b0, group_size});
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      in_byte[i] = bus.data_i[8*i +: 8];
    for (int i = 0; i < 10; i++) begin
      merged[i] = 8'h00;
      if (i < int'(count_q))
        merged[i] = byte_buf_q[i];
      else if (i - int'(count_q) < int'(take))
        merged[i] = in_byte[2'(i - int'(count_q))];
    end
    for (int i = 0; i < 10; i++) begin
      shifted[i] = merged[i];
      if (emit)
        shifted[i] = (i + int'(group_size) < 10) ? merged[i + int'(group_size)] : 8'h00;
    end
  end

  // The oldest bytes of the merged buffer always form the group being emitted.
  always_comb begin
    pixels = 64'h0;
    case (cur_type)
      TYPE_RAW10: begin
        for (int k = 0; k < 4; k++)
          pixels[16*k +: 16] = {6'h00, merged[k], merged[4][2*k +: 2]};
      end
      TYPE_RAW12: begin
        pixels[15:0]  = {4'h0, merged[0], merged[2][3:0]};
        pixels[31:16] = {4'h0, merged[1], merged[2][7:4]};
        pixels[47:32] = {4'h0, merged[3], merged[5][3:0]};
        pixels[63:48] = {4'h0, merged[4], merged[5][7:4]};
      end
      TYPE_RAW14: begin
        pixels[15:0]  = {2'h0, merged[0], merged[4][5:0]};
        pixels[31:16] = {2'h0, merged[1], merged[5][3:0], merged[4][7:6]};
        pixels[47:32] = {2'h0, merged[2], merged[6][1:0], merged[5][7:4]};
        pixels[63:48] = {2'h0, merged[3], merged[6][7:2]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_packet_q <= 1'b0;
      type_q      <= 3'd0;
      remaining_q <= 16'd0;
      count_q     <= 4'd0;
      for (int i = 0; i < 10; i++)
        byte_buf_q[i] <= 8'h00;
      out_valid_q <= 1'b0;
      pixel_q     <= 64'h0;
      depth_q     <= 2'd0;
    end else begin
      out_valid_q <= 1'b0;
      depth_q     <= 2'd0;
      if (!bus.data_valid_i) begin
        // Any residual partial group dies with the packet.
        in_packet_q <= 1'b0;
        remaining_q <= 16'd0;
        count_q     <= 4'd0;
      end else begin
        in_packet_q <= 1'b1;
        if (start)
          type_q <= bus.packet_type_i;
        remaining_q <= cur_remaining - {13'd0, take};
        count_q     <= emit ? 4'(total - {1'b0, group_size}) : total[3:0];
        for (int i = 0; i < 10; i++)
          byte_buf_q[i] <= shifted[i];
        if (emit) begin
          out_valid_q <= 1'b1;
          pixel_q     <= pixels;
          depth_q     <= depth;
        end
      end
    end
  end

  assign bus.output_valid_o = out_valid_q;
  assign bus.pixel_data_o   = pixel_q;
  assign bus.pixel_depth_o  = depth_q;
endmodule

// File: tb/tb_mipi_csi_rx_raw_depacker_8b4lane.sv
// Self-checking bench for the RAW depacker: byte-stream reference model plus directed literal checks.
// The model tracks each packet as a flat list of accepted bytes and slices groups out by index.
module tb_mipi_csi_rx_raw_depacker_8b4lane;
  logic clk_i = 1'b0;
  logic reset_i;
  int checks = 0;
  int errors = 0;

  mipi_csi_rx_raw_depacker_8b4lane_if bus ();

  mipi_csi_rx_raw_depacker_8b4lane dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  pkt_bytes [128];
  int          pulses;
  logic [31:0] hist;
  logic [63:0] first_pix;
  logic        got_first;

  logic        m_in_pkt;
  logic [2:0]  m_type;
  int          m_len;
  int          m_accepted;
  int          m_groups;
  int          m_g;
  logic [55:0] m_grp;
  logic [7:0]  m_bytes [$];
  logic        exp_valid;
  logic [63:0] exp_pix;
  logic [1:0]  exp_depth;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int groupBytes(input logic [2:0] t);
    case (t)
      3'd3: return 5;
      3'd4: return 6;
      3'd5: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] unpackGroup(input logic [2:0] t, input logic [55:0] g);
    int b [7];
    int p [4];
    for (int k = 0; k < 7; k++) b[k] = int'(g[8*k +: 8]);
    for (int k = 0; k < 4; k++) p[k] = 0;
    case (t)
      3'd3: for (int k = 0; k < 4; k++) p[k] = (b[k] * 4) + ((b[4] >> (2 * k)) % 4);
      3'd4: begin
        p[0] = b[0] * 16 + b[2] % 16;
        p[1] = b[1] * 16 + b[2] / 16;
        p[2] = b[3] * 16 + b[5] % 16;
        p[3] = b[4] * 16 + b[5] / 16;
      end
      3'd5: begin
        p[0] = b[0] * 64 + b[4] % 64;
        p[1] = b[1] * 64 + (b[5] % 16) * 4 + b[4] / 64;
        p[2] = b[2] * 64 + (b[6] % 4) * 16 + b[5] / 16;
        p[3] = b[3] * 64 + b[6] / 4;
      end
      default: ;
    endcase
    return {16'(p[3]), 16'(p[2]), 16'(p[1]), 16'(p[0])};
  endfunction

  // Reference model: expected outputs for the cycle after each posedge.
  always @(posedge clk_i) begin
    if (reset_i) begin
      m_in_pkt  = 1'b0;
      exp_valid = 1'b0;
      exp_pix   = 64'h0;
      exp_depth = 2'd0;
      m_bytes.delete();
    end else begin
      exp_valid = 1'b0;
      exp_depth = 2'd0;
      if (!bus.data_valid_i) begin
        m_in_pkt = 1'b0;
      end else begin
        if (!m_in_pkt) begin
          m_in_pkt   = 1'b1;
          m_type     = bus.packet_type_i;
          m_len      = int'(bus.packet_length_i);
          m_accepted = 0;
          m_groups   = 0;
          m_bytes.delete();
        end
        m_g = groupBytes(m_type);
        if (m_g != 0) begin
          for (int k = 0; k < 4; k++)
            if (m_accepted < m_len) begin
              m_bytes.push_back(bus.data_i[8*k +: 8]);
              m_accepted++;
            end
          if (m_bytes.size() >= (m_groups + 1) * m_g) begin
            m_grp = 56'h0;
            for (int k = 0; k < m_g; k++) m_grp[8*k +: 8] = m_bytes[m_groups * m_g + k];
            exp_pix   = unpackGroup(m_type, m_grp);
            exp_valid = 1'b1;
            exp_depth = 2'(m_type - 3'd2);
            m_groups++;
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    checkOutput("model_valid", {63'h0, bus.output_valid_o}, {63'h0, exp_valid});
    checkOutput("model_depth", {62'h0, bus.pixel_depth_o}, {62'h0, exp_depth});
    checkOutput("model_pixels", bus.pixel_data_o, exp_pix);
  end

  task automatic applyStimulus(input logic [2:0] t, input int len, input int ncyc, input int reset_at);
    pulses    = 0;
    hist      = 32'h0;
    first_pix = 64'h0;
    got_first = 1'b0;
    for (int c = 0; c < ncyc + 4; c++) begin
      @(posedge clk_i);
      #1;
      if (c > 0) begin
        if (bus.output_valid_o) begin
          if (!got_first) first_pix = bus.pixel_data_o;
          got_first = 1'b1;
          pulses++;
        end
        if (c - 1 < 32) hist[c-1] = bus.output_valid_o;
      end
      reset_i = (c == reset_at);
      if (c < ncyc) begin
        bus.data_valid_i    = 1'b1;
        bus.packet_type_i   = t;
        bus.packet_length_i = 16'(len);
        for (int k = 0; k < 4; k++) bus.data_i[8*k +: 8] = pkt_bytes[4*c + k];
      end else begin
        bus.data_valid_i    = 1'b0;
        bus.data_i          = $urandom;
        bus.packet_type_i   = 3'($urandom);
        bus.packet_length_i = 16'($urandom);
      end
    end
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 128; i++) pkt_bytes[i] = 8'($urandom);
  endtask

  initial begin
    int t, len, need, ncyc, rst_at;
    reset_i             = 1'b1;
    bus.data_valid_i    = 1'($urandom);
    bus.data_i          = $urandom;
    bus.packet_type_i   = 3'd3;
    bus.packet_length_i = 16'd20;

    for (int r = 0; r < 2; r++) begin
      @(posedge clk_i);
      #1;
      checkOutput("reset_valid", {63'h0, bus.output_valid_o}, 64'h0);
      checkOutput("reset_pixels", bus.pixel_data_o, 64'h0);
      checkOutput("reset_depth", {62'h0, bus.pixel_depth_o}, 64'h0);
      bus.data_valid_i = 1'($urandom);
      bus.data_i       = $urandom;
    end

    fillRandom();
    pkt_bytes[0] = 8'hFF; pkt_bytes[1] = 8'h00; pkt_bytes[2] = 8'hAA;
    pkt_bytes[3] = 8'h55; pkt_bytes[4] = 8'hE4;
    applyStimulus(3'd3, 20, 5, -1);
    checkOutput("raw10_p0", {48'h0, first_pix[15:0]}, 64'h03FC);
    checkOutput("raw10_p1", {48'h0, first_pix[31:16]}, 64'h0001);
    checkOutput("raw10_p2", {48'h0, first_pix[47:32]}, 64'h02AA);
    checkOutput("raw10_p3", {48'h0, first_pix[63:48]}, 64'h0157);
    checkOutput("raw10_groups", 64'(pulses), 64'd4);
    checkOutput("raw10_pattern", {59'h0, hist[4:0]}, 64'b11110);

    for (int i = 0; i < 12; i += 6) begin
      pkt_bytes[i]   = 8'h12; pkt_bytes[i+1] = 8'h34; pkt_bytes[i+2] = 8'h56;
      pkt_bytes[i+3] = 8'h78; pkt_bytes[i+4] = 8'h9A; pkt_bytes[i+5] = 8'hBC;
    end
    applyStimulus(3'd4, 12, 3, -1);
    checkOutput("raw12_pixels", first_pix, 64'h09AB_078C_0345_0126);
    checkOutput("raw12_groups", 64'(pulses), 64'd2);

    for (int i = 0; i < 128; i++) pkt_bytes[i] = 8'hFF;
    applyStimulus(3'd5, 28, 7, -1);
    checkOutput("raw14_ones", first_pix, 64'h3FFF_3FFF_3FFF_3FFF);
    checkOutput("raw14_groups", 64'(pulses), 64'd4);

    for (int i = 0; i < 128; i++) pkt_bytes[i] = 8'h00;
    pkt_bytes[4] = 8'h3F; pkt_bytes[5] = 8'h0F; pkt_bytes[6] = 8'h03;
    applyStimulus(3'd5, 7, 2, -1);
    checkOutput("raw14_bits", first_pix, 64'h0000_0030_003C_003F);
    checkOutput("raw14_one_group", 64'(pulses), 64'd1);

    fillRandom();
    applyStimulus(3'd3, 10, 4, -1);
    checkOutput("trunc_groups", 64'(pulses), 64'd2);

    fillRandom();
    applyStimulus(3'd5, 28, 1, -1);
    checkOutput("abort_groups", 64'(pulses), 64'd0);
    fillRandom();
    pkt_bytes[0] = 8'hFF; pkt_bytes[1] = 8'h00; pkt_bytes[2] = 8'hAA;
    pkt_bytes[3] = 8'h55; pkt_bytes[4] = 8'hE4;
    applyStimulus(3'd3, 5, 2, -1);
    checkOutput("after_abort_pixels", first_pix, 64'h0157_02AA_0001_03FC);
    checkOutput("after_abort_groups", 64'(pulses), 64'd1);

    fillRandom();
    applyStimulus(3'd2, 40, 10, -1);
    checkOutput("unsupported_groups", 64'(pulses), 64'd0);

    // Random packets: mixed types, odd lengths, early drops, trailing idle-valid words and resets.
    for (int n = 0; n < 40; n++) begin
      fillRandom();
      t = $urandom_range(0, 9);
      if (t == 0) t = 2;
      else if (t == 1) t = 7;
      else t = 3 + (t % 3);
      len  = $urandom_range(1, 60);
      need = (len + 3) / 4;
      ncyc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, need) : need + $urandom_range(0, 2);
      rst_at = ($urandom_range(0, 7) == 0 && ncyc > 1) ? $urandom_range(1, ncyc - 1) : -1;
      applyStimulus(3'(t), len, ncyc, rst_at);
    end

    @(posedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
